ar_credit_rbuf: RTL and testbench

AR_CREDIT_RBUF -- requirements
Module: ar_credit_rbuf

---
 rtl/ar_credit_rbuf.sv | 146 ++++++++++++++
 tb/tb_ar_credit_rbuf.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_credit_rbuf.sv
// ar_credit_rbuf: credit-gated AR pass-through with an in-order R beat buffer.
// Every AR forwarded to memory first reserves one buffer slot per beat, so the
// R channel toward memory can stay permanently ready without ever overflowing.
// Returned beats are queued in arrival order and replayed to the prefetcher.
module ar_credit_rbuf #(
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int LOG_DEPTH       = 3
) (
    input  logic                       clk,
    input  logic                       resetN,

    // read request from the prefetcher
    input  logic                       s_ar_valid,
    output logic                       s_ar_ready,
    input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
    input  logic [ADDR_BITS-1:0]       s_ar_addr,
    input  logic [TID_WIDTH-1:0]       s_ar_id,

    // read request to memory
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic [TID_WIDTH-1:0]       m_ar_id,

    // R channel from memory
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [DATA_WIDTH-1:0]      m_r_data,
    input  logic [TID_WIDTH-1:0]       m_r_id,
    input  logic                       m_r_last,

    // buffered R channel to the prefetcher
    output logic                       s_r_valid,
    input  logic                       s_r_ready,
    output logic [DATA_WIDTH-1:0]      s_r_data,
    output logic [TID_WIDTH-1:0]       s_r_id,
    output logic                       s_r_last,

    // bit0: oversize burst seen, bit1: unrequested R beat seen (both sticky)
    output logic [1:0]                 errorCode
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CW    = LOG_DEPTH + 1;          // counter width, holds 0..DEPTH
    localparam int NW    = BURST_LEN_WIDTH + 1;    // beats-per-burst width
    localparam int XW    = ((NW > CW) ? NW : CW) + 1; // common compare width
    localparam int EW    = DATA_WIDTH + TID_WIDTH + 1; // stored {data,id,last}

    // occupancy state
    logic [CW-1:0]        r_cnt;     // beats sitting in the buffer
    logic [CW-1:0]        r_outst;   // beats requested but not yet returned
    logic [LOG_DEPTH-1:0] r_wptr;
    logic [LOG_DEPTH-1:0] r_rptr;
    logic [1:0]           r_err;

    // beat storage; contents are meaningful only where s_r_valid says so
    logic [EW-1:0]        r_mem [DEPTH];

    logic [NW-1:0]        w_need;
    logic [XW-1:0]        w_need_x;
    logic [CW-1:0]        w_need_c;
    logic [CW-1:0]        w_free;
    logic                 w_grant;
    logic                 w_oversize;
    logic                 w_ar_hs;
    logic                 w_wr;
    logic                 w_drop;
    logic                 w_pop;
    logic [CW-1:0]        w_ar_add;
    logic [CW-1:0]        w_wr_inc;
    logic [CW-1:0]        w_pop_dec;
    logic [EW-1:0]        w_head;

    // credit check: a burst may go out only if every beat already has a slot
    always_comb begin
        w_need     = {1'b0, s_ar_len} + NW'(1);
        w_need_x   = XW'(w_need);
        w_need_c   = w_need_x[CW-1:0];
        w_free     = CW'(DEPTH) - r_cnt - r_outst;
        w_grant    = (w_need_x <= XW'(w_free));
        // anything longer than the whole buffer can never be granted
        w_oversize = (w_need_x > XW'(DEPTH));
    end

    // AR passes straight through, gated by credit; held low while in reset
    assign m_ar_valid = s_ar_valid & w_grant & resetN;
    assign s_ar_ready = m_ar_ready & w_grant & resetN;
    assign m_ar_len   = s_ar_len;
    assign m_ar_addr  = s_ar_addr;
    assign m_ar_id    = s_ar_id;

    // every accepted beat was pre-reserved, so memory is never back-pressured
    assign m_r_ready  = 1'b1;

    // per-cycle events; all three may coincide and are applied as a net update
    always_comb begin
        w_ar_hs   = s_ar_valid & m_ar_ready & w_grant;
        w_wr      = m_r_valid & (r_outst != '0);
        w_drop    = m_r_valid & (r_outst == '0);
        w_pop     = (r_cnt != '0) & s_r_ready;
        w_ar_add  = w_ar_hs ? w_need_c : '0;
        w_wr_inc  = {{(CW-1){1'b0}}, w_wr};
        w_pop_dec = {{(CW-1){1'b0}}, w_pop};
    end

    // counters, pointers and sticky error flags
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt   <= '0;
            r_outst <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_err   <= '0;
        end else begin
            r_outst <= r_outst + w_ar_add - w_wr_inc;
            r_cnt   <= r_cnt + w_wr_inc - w_pop_dec;
            if (w_wr)
                r_wptr <= r_wptr + LOG_DEPTH'(1);
            if (w_pop)
                r_rptr <= r_rptr + LOG_DEPTH'(1);
            if (s_ar_valid && w_oversize)
                r_err[0] <= 1'b1;
            if (w_drop)
                r_err[1] <= 1'b1;
        end
    end

    // beat storage write; unrequested beats never touch the array
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= {m_r_data, m_r_id, m_r_last};
    end

    // head slot drives the prefetcher side directly, no extra pipeline stage
    assign w_head    = r_mem[r_rptr];
    assign s_r_valid = (r_cnt != '0);
    assign s_r_data  = w_head[EW-1 -: DATA_WIDTH];
    assign s_r_id    = w_head[TID_WIDTH:1];
    assign s_r_last  = w_head[0];
    assign errorCode = r_err;

endmodule

// File: tb/tb_ar_credit_rbuf.sv
// Directed bench for ar_credit_rbuf at DEPTH=8.
module tb_ar_credit_rbuf;

    logic        clk = 1'b0;
    logic        resetN;
    logic        s_ar_valid, s_ar_ready;
    logic [7:0]  s_ar_len;
    logic [15:0] s_ar_addr;
    logic [7:0]  s_ar_id;
    logic        m_ar_valid, m_ar_ready;
    logic [7:0]  m_ar_len;
    logic [15:0] m_ar_addr;
    logic [7:0]  m_ar_id;
    logic        m_r_valid, m_r_ready;
    logic [7:0]  m_r_data, m_r_id;
    logic        m_r_last;
    logic        s_r_valid, s_r_ready;
    logic [7:0]  s_r_data, s_r_id;
    logic        s_r_last;
    logic [1:0]  errorCode;

    int n_run  = 0;
    int n_fail = 0;

    ar_credit_rbuf #(
        .ADDR_BITS(16), .BURST_LEN_WIDTH(8), .TID_WIDTH(8),
        .DATA_WIDTH(8), .LOG_DEPTH(3)
    ) dut (
        .clk(clk), .resetN(resetN),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_len(s_ar_len),
        .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_len(m_ar_len),
        .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
        .m_r_id(m_r_id), .m_r_last(m_r_last),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
        .s_r_id(s_r_id), .s_r_last(s_r_last),
        .errorCode(errorCode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_ar_valid = 0; s_ar_len = 0; s_ar_addr = 0; s_ar_id = 0;
        m_ar_ready = 1; m_r_valid = 0; m_r_data = 0; m_r_id = 0; m_r_last = 0;
        s_r_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetN = 0;
        tick();
        tick();
        resetN = 1;
        #1;
    endtask

    // one memory beat, presented for exactly one edge
    task automatic r_beat(input logic [7:0] d, input logic [7:0] id, input logic last);
        m_r_valid = 1; m_r_data = d; m_r_id = id; m_r_last = last;
        tick();
        m_r_valid = 0;
        #1;
    endtask

    initial begin
        idle_inputs();
        resetN = 0;
        #1;
        chk("rst_s_r_valid", s_r_valid, 0);
        chk("rst_m_ar_valid", m_ar_valid, 0);
        chk("rst_err", errorCode, 0);
        chk("rst_m_r_ready", m_r_ready, 1);
        do_reset();

        // ---- single beat round trip
        s_ar_valid = 1; s_ar_len = 0; s_ar_addr = 16'h0eef; s_ar_id = 8'h03;
        #1;
        chk("t1_m_ar_valid", m_ar_valid, 1);
        chk("t1_s_ar_ready", s_ar_ready, 1);
        chk("t1_m_ar_addr", m_ar_addr, 16'h0eef);
        chk("t1_m_ar_len", m_ar_len, 0);
        chk("t1_m_ar_id", m_ar_id, 8'h03);
        tick();
        s_ar_valid = 0;
        #1;
        chk("t1_outst", dut.r_outst, 1);
        chk("t1_no_rvalid", s_r_valid, 0);
        r_beat(8'h05, 8'h03, 1);
        chk("t1_s_r_valid", s_r_valid, 1);
        chk("t1_s_r_data", s_r_data, 8'h05);
        chk("t1_s_r_last", s_r_last, 1);
        chk("t1_s_r_id", s_r_id, 8'h03);
        chk("t1_outst0", dut.r_outst, 0);
        s_r_ready = 1;
        tick();
        s_r_ready = 0;
        #1;
        chk("t1_drained", s_r_valid, 0);

        // ---- credit stall: three len=2 requests into 8 slots
        do_reset();
        s_ar_valid = 1; s_ar_len = 2; s_ar_addr = 16'h0100;
        #1;
        chk("t2_ar0_ready", s_ar_ready, 1);
        tick();
        chk("t2_outst3", dut.r_outst, 3);
        chk("t2_ar1_ready", s_ar_ready, 1);
        tick();
        chk("t2_outst6", dut.r_outst, 6);
        chk("t2_ar2_stall", s_ar_ready, 0);
        chk("t2_ar2_mvalid", m_ar_valid, 0);
        for (int i = 0; i < 6; i++) begin
            r_beat(8'h10 + 8'(i), 8'h01, (i % 3) == 2);
            chk("t2_stall_during_beats", s_ar_ready, 0);
        end
        chk("t2_cnt6", dut.r_cnt, 6);
        chk("t2_outst0", dut.r_outst, 0);
        s_r_ready = 1;
        #1;
        chk("t2_head", s_r_data, 8'h10);
        tick();
        s_r_ready = 0;
        #1;
        chk("t2_ar2_granted", s_ar_ready, 1);
        tick();
        s_ar_valid = 0;
        #1;
        chk("t2_outst_after", dut.r_outst, 3);
        chk("t2_cnt5", dut.r_cnt, 5);
        s_r_ready = 1;
        for (int i = 1; i < 6; i++) begin
            chk("t2_order", s_r_data, 8'h10 + 8'(i));
            tick();
        end
        s_r_ready = 0;
        #1;
        chk("t2_empty", s_r_valid, 0);

        // ---- exact-fit and oversize bursts
        do_reset();
        s_ar_valid = 1; s_ar_len = 7;
        #1;
        chk("t3_len7_ready", s_ar_ready, 1);
        tick();
        s_ar_valid = 0;
        #1;
        chk("t3_len7_outst", dut.r_outst, 8);
        chk("t3_len7_err", errorCode, 0);
        do_reset();
        s_ar_valid = 1; s_ar_len = 8;
        #1;
        chk("t3_len8_ready", s_ar_ready, 0);
        chk("t3_len8_mvalid", m_ar_valid, 0);
        chk("t3_err_not_yet", errorCode, 0);
        tick();
        chk("t3_len8_err", errorCode, 2'b01);
        tick();
        tick();
        chk("t3_len8_still_stalled", s_ar_ready, 0);
        chk("t3_len8_outst", dut.r_outst, 0);
        s_ar_valid = 0;
        tick();
        chk("t3_err_sticky", errorCode, 2'b01);

        // ---- unrequested beat
        do_reset();
        r_beat(8'hAA, 8'h00, 1);
        chk("t4_no_rvalid", s_r_valid, 0);
        chk("t4_err", errorCode, 2'b10);
        chk("t4_cnt", dut.r_cnt, 0);
        chk("t4_outst", dut.r_outst, 0);

        // ---- full occupancy streaming across pointer wrap
        do_reset();
        s_ar_valid = 1; s_ar_len = 7;
        tick();
        s_ar_valid = 0;
        for (int i = 0; i < 8; i++) r_beat(8'(i), 8'h02, i == 7);
        chk("t5_full", dut.r_cnt, 8);
        s_ar_valid = 1; s_ar_len = 0;
        #1;
        chk("t5_full_no_credit", s_ar_ready, 0);
        s_ar_valid = 0;
        s_r_ready = 1;
        #1;
        chk("t5_pop0", s_r_data, 0);
        tick();
        s_r_ready = 0;
        for (int i = 0; i < 6; i++) begin
            // reclaim the freed slot, then push and pop in one cycle
            s_ar_valid = 1; s_ar_len = 0;
            #1;
            chk("t5_credit", s_ar_ready, 1);
            tick();
            s_ar_valid = 0;
            s_r_ready = 1;
            m_r_valid = 1; m_r_data = 8'(8 + i); m_r_id = 8'h02; m_r_last = 1;
            #1;
            chk("t5_stream_order", s_r_data, 8'(1 + i));
            tick();
            m_r_valid = 0; s_r_ready = 0;
            #1;
            chk("t5_cnt_steady", dut.r_cnt, 7);
            chk("t5_outst0", dut.r_outst, 0);
        end
        s_r_ready = 1;
        for (int i = 7; i < 14; i++) begin
            chk("t5_tail_order", s_r_data, 8'(i));
            tick();
        end
        s_r_ready = 0;
        #1;
        chk("t5_empty", s_r_valid, 0);
        chk("t5_err", errorCode, 0);

        // ---- asynchronous reset mid-burst
        do_reset();
        r_beat(8'h77, 8'h00, 0);
        s_ar_valid = 1; s_ar_len = 4;
        tick();
        s_ar_valid = 0;
        for (int i = 0; i < 3; i++) r_beat(8'h30 + 8'(i), 8'h04, 0);
        chk("t6_cnt3", dut.r_cnt, 3);
        chk("t6_outst2", dut.r_outst, 2);
        chk("t6_err_pre", errorCode, 2'b10);
        s_ar_valid = 1; s_ar_len = 0;
        #2;
        resetN = 0;
        #1;
        chk("t6_cnt", dut.r_cnt, 0);
        chk("t6_outst", dut.r_outst, 0);
        chk("t6_err", errorCode, 0);
        chk("t6_s_r_valid", s_r_valid, 0);
        chk("t6_m_ar_valid", m_ar_valid, 0);
        chk("t6_wptr", dut.r_wptr, 0);
        s_ar_valid = 0;
        tick();
        resetN = 1;
        #1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
